// File: rtl/apx_pkg.sv
// Shared definitions for the apx accumulator family: FSM state encoding and
// a generic unsigned saturating add usable at any width up to 64 bits.
package apx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int SAT_MAXW = 64;

  // Returns {ovf, sum}; sum is clamped to 2^w-1 when the true result does not fit in w bits.
  function automatic logic [SAT_MAXW:0] sat_add(input logic [SAT_MAXW-1:0] a,
                                                input logic [SAT_MAXW-1:0] b,
                                                input int unsigned w);
    logic [SAT_MAXW:0] full;
    logic [SAT_MAXW:0] lim;
    full = {1'b0, a} + {1'b0, b};
    lim  = ({{SAT_MAXW{1'b0}}, 1'b1} << w) - {{SAT_MAXW{1'b0}}, 1'b1};
    if (full > lim) sat_add = {1'b1, lim[SAT_MAXW-1:0]};
    else            sat_add = {1'b0, full[SAT_MAXW-1:0]};
  endfunction

endpackage

// File: rtl/apx_sat_add.sv
// Unsigned saturating adder of parameterised width; purely combinational.
// ovf flags that the true sum did not fit and sum was forced to all ones.
module apx_sat_add #(
  parameter int W = 38
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W:0] full;

  assign full = {1'b0, a} + {1'b0, b};
  assign ovf  = full[W];
  assign sum  = full[W] ? {W{1'b1}} : full[W-1:0];

endmodule

// File: rtl/apx_dot_acc.sv
// Saturating dot-product accumulator for the btm product stream: sums i_len
// products and hands the result downstream with a valid/ready handshake.
//
// state   | meaning
// IDLE    | waiting for i_start; previous result still on o_acc/o_ovf
// ACC     | accepting products, one per cycle, until cnt reaches zero
// HOLD    | result valid, waiting for i_acc_rdy
module apx_dot_acc
  import apx_pkg::*;
#(
  parameter int BWOP = 32,
  parameter int NAB  = 1,
  parameter int ACCW = 40,
  parameter int LEN  = 16,
  localparam int LENW = $clog2(LEN + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [LENW-1:0] i_len,
  input  logic            i_prod_vld,
  output logic            o_prod_rdy,
  input  logic [BWOP-1:0] i_prod,
  output logic            o_acc_vld,
  input  logic            i_acc_rdy,
  output logic [ACCW-1:0] o_acc,
  output logic            o_ovf,
  output logic            o_busy
);

  // The low 2*NAB product bits are structurally zero, so they are never stored.
  localparam int AW = ACCW - 2*NAB;
  localparam int PW = BWOP - 2*NAB;

  state_t          state, state_nxt;
  logic [AW-1:0]   acc, add_b, add_sum;
  logic            add_ovf;
  logic [LENW-1:0] cnt, len_c;
  logic            ovf;
  logic            hs;

  assign add_b = {{(AW-PW){1'b0}}, i_prod[BWOP-1:2*NAB]};
  assign len_c = (i_len > LENW'(LEN)) ? LENW'(LEN) : i_len;
  assign hs    = (state == ST_ACC) && i_prod_vld;

  apx_sat_add #(.W(AW)) u_sat_add (
    .a   (acc),
    .b   (add_b),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_comb begin
    state_nxt  = state;
    o_prod_rdy = 1'b0;
    o_acc_vld  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (i_start) state_nxt = (len_c == '0) ? ST_HOLD : ST_ACC;
      end
      ST_ACC: begin
        o_prod_rdy = 1'b1;
        if (i_prod_vld && cnt == LENW'(1)) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        o_acc_vld = 1'b1;
        if (i_acc_rdy) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (state == ST_IDLE && i_start) begin
      acc <= '0;
      ovf <= 1'b0;
      cnt <= len_c;
    end else if (hs) begin
      acc <= add_sum;
      ovf <= ovf | add_ovf;
      cnt <= cnt - LENW'(1);
    end
  end

  assign o_acc  = {acc, {(2*NAB){1'b0}}};
  assign o_ovf  = ovf;
  assign o_busy = (state != ST_IDLE);

`ifndef SYNTHESIS
  // Upstream multiplier guarantees zero low bits; dropping them must lose nothing.
  always @(posedge i_clk) begin
    if (i_rst_n && state == ST_ACC && i_prod_vld)
      assert (i_prod[2*NAB-1:0] == '0)
        else $error("apx_dot_acc: nonzero low product bits %h", i_prod);
  end
`endif

endmodule

// File: tb/tb_apx_dot_acc.sv
// Directed bench for apx_dot_acc: default instance plus a narrow ACCW=34
// instance used for the saturation runs.
module tb_apx_dot_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // default instance (ACCW=40)
  logic        start, prod_vld, acc_rdy;
  logic [4:0]  len;
  logic [31:0] prod;
  logic        prod_rdy, acc_vld, ovf, busy;
  logic [39:0] acc;

  // narrow instance (ACCW=34)
  logic        start_b, prod_vld_b, acc_rdy_b;
  logic [4:0]  len_b;
  logic [31:0] prod_b;
  logic        prod_rdy_b, acc_vld_b, ovf_b, busy_b;
  logic [33:0] acc_b;

  int vectors = 0;
  int miscompares = 0;

  apx_dot_acc dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_len(len),
    .i_prod_vld(prod_vld), .o_prod_rdy(prod_rdy), .i_prod(prod),
    .o_acc_vld(acc_vld), .i_acc_rdy(acc_rdy), .o_acc(acc),
    .o_ovf(ovf), .o_busy(busy)
  );

  apx_dot_acc #(.ACCW(34)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_len(len_b),
    .i_prod_vld(prod_vld_b), .o_prod_rdy(prod_rdy_b), .i_prod(prod_b),
    .o_acc_vld(acc_vld_b), .i_acc_rdy(acc_rdy_b), .o_acc(acc_b),
    .o_ovf(ovf_b), .o_busy(busy_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_start(input logic [4:0] l);
    start = 1'b1; len = l; step(); start = 1'b0;
  endtask

  task automatic feed(input logic [31:0] v);
    prod_vld = 1'b1; prod = v; step();
  endtask

  task automatic accept();
    acc_rdy = 1'b1; step(); acc_rdy = 1'b0;
  endtask

  task automatic run_start_b(input logic [4:0] l);
    start_b = 1'b1; len_b = l; step(); start_b = 1'b0;
  endtask

  task automatic feed_b(input logic [31:0] v);
    prod_vld_b = 1'b1; prod_b = v; step();
  endtask

  task automatic accept_b();
    acc_rdy_b = 1'b1; step(); acc_rdy_b = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 0; len = 0; prod_vld = 0; prod = 0; acc_rdy = 0;
    start_b = 0; len_b = 0; prod_vld_b = 0; prod_b = 0; acc_rdy_b = 0;
    repeat (2) step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_acc_vld", 64'(acc_vld), 64'd0);
    chk("rst_acc", 64'(acc), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_prod_rdy", 64'(prod_rdy), 64'd0);
    rst_n = 1'b1;
    step();

    // back-to-back run of four products
    run_start(5'd4);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_prod_rdy", 64'(prod_rdy), 64'd1);
    feed(32'd4); feed(32'd8); feed(32'd12);
    chk("t1_vld_early", 64'(acc_vld), 64'd0);
    feed(32'd16); prod_vld = 1'b0;
    chk("t1_vld", 64'(acc_vld), 64'd1);
    chk("t1_acc", 64'(acc), 64'd40);
    chk("t1_ovf", 64'(ovf), 64'd0);
    chk("t1_rdy_hold", 64'(prod_rdy), 64'd0);
    accept();
    chk("t1_idle_busy", 64'(busy), 64'd0);
    chk("t1_idle_vld", 64'(acc_vld), 64'd0);
    chk("t1_idle_acc", 64'(acc), 64'd40);

    // gapped products, result held against backpressure
    run_start(5'd3);
    feed(32'd100); prod_vld = 1'b0; prod = 32'hDEAD_BEEF; step();
    chk("t2_gap1_acc", 64'(acc), 64'd100);
    feed(32'd200); prod_vld = 1'b0; step();
    chk("t2_gap2_acc", 64'(acc), 64'd300);
    feed(32'd300); prod_vld = 1'b0;
    chk("t2_vld", 64'(acc_vld), 64'd1);
    chk("t2_acc", 64'(acc), 64'd600);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_hold_acc", 64'(acc), 64'd600);
      chk("t2_hold_vld", 64'(acc_vld), 64'd1);
    end
    accept();
    chk("t2_idle_busy", 64'(busy), 64'd0);

    // zero-length run: straight to HOLD, nothing consumed
    prod_vld = 1'b1; prod = 32'd4;
    run_start(5'd0);
    chk("t4_vld", 64'(acc_vld), 64'd1);
    chk("t4_acc", 64'(acc), 64'd0);
    chk("t4_ovf", 64'(ovf), 64'd0);
    chk("t4_prod_rdy", 64'(prod_rdy), 64'd0);
    accept();
    prod_vld = 1'b0;
    chk("t4_idle_acc", 64'(acc), 64'd0);
    chk("t4_idle_busy", 64'(busy), 64'd0);

    // start during ACC is ignored
    run_start(5'd3);
    feed(32'd4);
    start = 1'b1; len = 5'd7;
    feed(32'd4);
    start = 1'b0;
    feed(32'd4); prod_vld = 1'b0;
    chk("t6_vld", 64'(acc_vld), 64'd1);
    chk("t6_acc", 64'(acc), 64'd12);
    accept();
    chk("t6_idle_busy", 64'(busy), 64'd0);

    // length above LEN clamps to 16
    run_start(5'd20);
    for (int i = 0; i < 15; i++) feed(32'd4);
    chk("clamp_vld_early", 64'(acc_vld), 64'd0);
    chk("clamp_busy", 64'(busy), 64'd1);
    feed(32'd4); prod_vld = 1'b0;
    chk("clamp_vld", 64'(acc_vld), 64'd1);
    chk("clamp_acc", 64'(acc), 64'd64);
    accept();

    // reset mid-run
    run_start(5'd5);
    feed(32'd40); feed(32'd40); prod_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_vld", 64'(acc_vld), 64'd0);
    chk("t5_acc", 64'(acc), 64'd0);
    chk("t5_prod_rdy", 64'(prod_rdy), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    run_start(5'd1);
    feed(32'd100); prod_vld = 1'b0;
    chk("t5_new_vld", 64'(acc_vld), 64'd1);
    chk("t5_new_acc", 64'(acc), 64'd100);
    accept();

    // narrow accumulator: just fits, then saturates with sticky ovf
    run_start_b(5'd4);
    for (int i = 0; i < 4; i++) feed_b(32'hFFFF_FFFC);
    prod_vld_b = 1'b0;
    chk("t3_fit_vld", 64'(acc_vld_b), 64'd1);
    chk("t3_fit_acc", 64'(acc_b), 64'h3_FFFF_FFF0);
    chk("t3_fit_ovf", 64'(ovf_b), 64'd0);
    accept_b();
    run_start_b(5'd6);
    for (int i = 0; i < 5; i++) feed_b(32'hFFFF_FFFC);
    feed_b(32'd0); prod_vld_b = 1'b0;
    chk("t3_sat_vld", 64'(acc_vld_b), 64'd1);
    chk("t3_sat_acc", 64'(acc_b), 64'h3_FFFF_FFFC);
    chk("t3_sat_ovf", 64'(ovf_b), 64'd1);
    accept_b();
    chk("t3_idle_ovf", 64'(ovf_b), 64'd1);
    run_start_b(5'd1);
    chk("t3_restart_ovf", 64'(ovf_b), 64'd0);
    feed_b(32'd8); prod_vld_b = 1'b0;
    chk("t3_next_acc", 64'(acc_b), 64'd8);
    chk("t3_next_ovf", 64'(ovf_b), 64'd0);
    accept_b();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
